// File: rtl/ifetch_queue.sv
// ifetch_queue: line-buffered instruction fetch front end for the LC-3b pipeline.
// Whole cache lines are read over a wishbone port. Sequential instruction words
// are pulled out of each line and pushed into a DEPTH-entry queue, which hands
// them to decode with a valid/ready handshake. A redirect from write-back
// flushes the queue and any fetch in flight, then restarts fetch at the new PC.
//
// Build option: define IFETCH_LINE_REUSE_EN to keep the last fetched line in a
// tagged buffer so that later words in the same line hit without a bus access.
// With the macro undefined, no tag/valid/data storage is built and every word
// costs its own bus access.

// One queue entry. It is cleared on reset so the head outputs read as zero.
module ifq_slot #(
  parameter int ENT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ENT_W-1:0] d,
  output logic [ENT_W-1:0] q
);
  // capture the enqueued entry; reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module ifetch_queue #(
  parameter int                WORD_W     = 16,
  parameter int                LINE_WORDS = 8,
  parameter int                DEPTH      = 4,
  parameter logic [WORD_W-1:0] RESET_PC   = '0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   redirect_i,
  input  logic [WORD_W-1:0]                      redirect_pc_i,
  output logic [WORD_W-$clog2(LINE_WORDS)-2:0]   wb_adr_o,
  input  logic [WORD_W*LINE_WORDS-1:0]           wb_dat_i,
  input  logic                                   wb_ack_i,
  output logic                                   wb_stb_o,
  output logic                                   wb_cyc_o,
  output logic                                   wb_we_o,
  output logic [WORD_W-1:0]                      instr_o,
  output logic [WORD_W-1:0]                      pc_o,
  output logic [WORD_W-1:0]                      npc_o,
  output logic                                   valid_o,
  input  logic                                   ready_i
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF   = IDX_W + 1;          // PC bits below the line address
  localparam int TAG_W = WORD_W - OFF;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // npc is stored with the entry so the head reads all-zero after reset
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] instr;
  } entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  state_t                            state;
  logic                              stb;
  logic [WORD_W-1:0]                 fetch_pc;
  logic [TAG_W-1:0]                  fetch_line;
  logic [IDX_W-1:0]                  word_idx;
  logic [LINE_WORDS-1:0][WORD_W-1:0] src_words;
  logic                              hit;
  logic                              full;
  logic                              enq;
  logic                              deq;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [CNT_W-1:0]                  count;
  entry_t                            enq_ent;
  entry_t [DEPTH-1:0]                slot_q;
  entry_t                            head;

  assign fetch_line = fetch_pc[WORD_W-1:OFF];
  assign word_idx   = fetch_pc[OFF-1:1];

`ifdef IFETCH_LINE_REUSE_EN
  logic [TAG_W-1:0]             buf_tag;
  logic                         buf_vld;
  logic [WORD_W*LINE_WORDS-1:0] line_buf;

  assign hit = buf_vld && (buf_tag == fetch_line);
  // in BUS the word bypasses straight from the bus; otherwise it comes from the buffer
  assign src_words = (state == S_BUS) ? wb_dat_i : line_buf;

  // latch the returned line; an ack that coincides with a redirect is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_vld <= 1'b0;
    end else if (!redirect_i && (state == S_BUS) && wb_ack_i) begin
      buf_vld  <= 1'b1;
      buf_tag  <= fetch_line;
      line_buf <= wb_dat_i;
    end
  end
`else
  assign hit       = 1'b0;
  assign src_words = wb_dat_i;
`endif

  assign full = (count == CNT_W'(DEPTH));
  assign deq  = valid_o && ready_i;
  // full is the pre-dequeue state, so a full queue blocks enqueue even while
  // draining; entering BUS requires !full and only dequeues occur there, so
  // the ack never finds the queue full
  assign enq  = !redirect_i &&
                (((state == S_IDLE) && !full && hit) ||
                 ((state == S_BUS) && wb_ack_i));

  assign enq_ent.pc    = fetch_pc;
  assign enq_ent.npc   = fetch_pc + WORD_W'(2);
  assign enq_ent.instr = src_words[word_idx];

  // fetch FSM: stream hits from the buffer, or wait on the bus for a miss
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      stb      <= 1'b0;
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      state    <= S_IDLE;
      stb      <= 1'b0;
      fetch_pc <= redirect_pc_i & ~WORD_W'(1);
    end else begin
      case (state)
        S_IDLE: begin
          if (!full) begin
            if (hit) begin
              fetch_pc <= fetch_pc + WORD_W'(2);
            end else begin
              state <= S_BUS;
              stb   <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            fetch_pc <= fetch_pc + WORD_W'(2);
            state    <= S_IDLE;
            stb      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          stb   <= 1'b0;
        end
      endcase
    end
  end

  // queue pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    ifq_slot #(.ENT_W($bits(entry_t))) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (enq && (wr_ptr == PTR_W'(i))),
      .d     (enq_ent),
      .q     (slot_q[i])
    );
  end

  assign head     = slot_q[rd_ptr];
  assign instr_o  = head.instr;
  assign pc_o     = head.pc;
  assign npc_o    = head.npc;
  assign valid_o  = (count != '0);

  assign wb_adr_o = fetch_line;
  assign wb_stb_o = stb;
  assign wb_cyc_o = stb;
  assign wb_we_o  = 1'b0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue. Memory word at byte address a is 0x1000 + a/2. The
// reference is the accepted-instruction stream: consecutive PCs from the
// reset/redirect PC, each carrying its memory word and PC+2. Bus accesses are
// counted and compared against line/word arithmetic.
module tb_ifetch_queue;
  localparam int W  = 16;
  localparam int LW = 8;
  localparam int AW = W - $clog2(LW) - 1;

`ifdef IFETCH_LINE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic          rst_n, redirect_i, ready_i;
  logic [W-1:0]  redirect_pc_i, instr_o, pc_o, npc_o;
  logic [AW-1:0] wb_adr_o;
  logic [W*LW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_stb_o, wb_cyc_o, wb_we_o, valid_o;

  // wrap instance (RESET_PC = 0xFFFC)
  logic          rst_w_n, ready_w;
  logic [W-1:0]  instr_w, pc_w, npc_w;
  logic [AW-1:0] adr_w;
  logic [W*LW-1:0] dat_w = '0;
  logic          ack_w = 1'b0;
  logic          stb_w, cyc_w, we_w, valid_w;

  ifetch_queue dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
    .instr_o(instr_o), .pc_o(pc_o), .npc_o(npc_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  ifetch_queue #(.RESET_PC(16'hFFFC)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .redirect_i(1'b0), .redirect_pc_i(16'h0000),
    .wb_adr_o(adr_w), .wb_dat_i(dat_w), .wb_ack_i(ack_w),
    .wb_stb_o(stb_w), .wb_cyc_o(cyc_w), .wb_we_o(we_w),
    .instr_o(instr_w), .pc_o(pc_w), .npc_o(npc_w), .valid_o(valid_w), .ready_i(ready_w)
  );

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return 16'h1000 + {1'b0, a[W-1:1]};
  endfunction

  function automatic logic [W*LW-1:0] line_data(input logic [AW-1:0] l);
    logic [W*LW-1:0] d;
    for (int k = 0; k < LW; k++) d[W*k +: W] = mem_word({l, 3'(k), 1'b0});
    return d;
  endfunction

  // bus slave for the main instance: ack after lat (or random) wait cycles
  int lat = 0;
  bit rand_lat = 1'b0;
  int wcnt = 0;
  int n_ack = 0;
  always @(posedge clk) begin
    wb_ack_i <= 1'b0;
    if (!wb_stb_o || wb_ack_i) begin
      wcnt <= rand_lat ? int'($urandom_range(0, 3)) : lat;
    end else if (wcnt == 0) begin
      wb_ack_i <= 1'b1;
      wb_dat_i <= line_data(wb_adr_o);
      n_ack    <= n_ack + 1;
    end else begin
      wcnt <= wcnt - 1;
    end
  end

  // bus slave for the wrap instance: ack one cycle after stb
  int n_ack_w = 0;
  always @(posedge clk) begin
    ack_w <= stb_w && !ack_w;
    dat_w <= line_data(adr_w);
    if (stb_w && !ack_w) n_ack_w <= n_ack_w + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_pc = '0;
  int n_deq = 0, cycn = 0, first_deq = 0, last_deq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // one clock; a head accepted at the coming edge is checked against the stream model
  task automatic cyc();
    @(negedge clk);
    if (rst_n && !redirect_i && valid_o && ready_i) begin
      chk("pc", pc_o, exp_pc);
      chk("instr", instr_o, mem_word(exp_pc));
      chk("npc", npc_o, 16'(exp_pc + 16'd2));
      if (n_deq == 0) first_deq = cycn;
      last_deq = cycn;
      exp_pc = 16'(exp_pc + 16'd2);
      n_deq++;
    end
    @(posedge clk);
    #1;
    cycn++;
  endtask

  initial begin
    logic [W-1:0] wexp;
    logic [W-1:0] held;
    int got, d0;
    rst_n = 1'b0; rst_w_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    ready_i = 1'b0; ready_w = 1'b1;
    repeat (2) cyc();

    // reset state
    chk("rst_valid", valid_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_npc", npc_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_w_adr", adr_w, 12'hFFF);

    // PC wrap from RESET_PC 0xFFFC
    rst_w_n = 1'b1;
    wexp = 16'hFFFC;
    got = 0;
    for (int t = 0; t < 60 && got < 3; t++) begin
      @(negedge clk);
      if (valid_w) begin
        chk("wrap_pc", pc_w, wexp);
        chk("wrap_instr", instr_w, mem_word(wexp));
        chk("wrap_npc", npc_w, 16'(wexp + 16'd2));
        wexp = 16'(wexp + 16'd2);
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("wrap_words", got, 3);
    chk("wrap_acks", n_ack_w, REUSE ? 2 : 3);
    chk("wrap_adr", adr_w, 0);
    rst_w_n = 1'b0;

    // line 0 streamed after one bus access, then line 1 requested
    rst_n = 1'b1; ready_i = 1'b1; lat = 0;
    for (int t = 0; t < 100 && n_deq < 8; t++) cyc();
    chk("seq_words", n_deq, 8);
    chk("seq_acks", n_ack, REUSE ? 1 : 8);
    chk("seq_span", last_deq - first_deq, REUSE ? 7 : 21);
    for (int t = 0; t < 20 && !wb_stb_o; t++) cyc();
    chk("seq_stb", wb_stb_o, 1);
    chk("seq_adr", wb_adr_o, 1);

    // stall: queue fills to DEPTH, bus goes quiet, head holds
    ready_i = 1'b0;
    repeat (30) cyc();
    chk("full_valid", valid_o, 1);
    chk("full_head_pc", pc_o, exp_pc);
    held = instr_o;
    chk("full_head", held, mem_word(exp_pc));
    chk("full_acks", n_ack, REUSE ? ((32'(exp_pc) + 6) >> 4) + 1 : n_deq + 4);
    for (int t = 0; t < 6; t++) begin
      cyc();
      chk("full_stb", wb_stb_o, 0);
      chk("full_hold", instr_o, held);
    end

    // redirect to 0x0031 with the queue non-empty
    ready_i = 1'b1; cyc();
    ready_i = 1'b0; lat = 3;
    chk("pre_redir_valid", valid_o, 1);
    redirect_i = 1'b1; redirect_pc_i = 16'h0031; cyc();
    redirect_i = 1'b0; exp_pc = 16'h0030;
    chk("redir_valid", valid_o, 0);
    for (int t = 0; t < 20 && !wb_stb_o; t++) cyc();
    chk("redir_stb", wb_stb_o, 1);
    chk("redir_adr", wb_adr_o, 3);

    // redirect in the same cycle as the ack: word dropped, line not buffered
    for (int t = 0; t < 20 && !wb_ack_i; t++) cyc();
    chk("ack_seen", wb_ack_i, 1);
    redirect_i = 1'b1; redirect_pc_i = 16'h0037; cyc();
    redirect_i = 1'b0; exp_pc = 16'h0036;
    chk("ackredir_valid", valid_o, 0);
    for (int t = 0; t < 20 && !wb_stb_o; t++) cyc();
    chk("ackredir_stb", wb_stb_o, 1);
    chk("ackredir_adr", wb_adr_o, 3);
    ready_i = 1'b1;
    d0 = n_deq;
    for (int t = 0; t < 150 && n_deq < d0 + 6; t++) cyc();
    chk("ackredir_words", n_deq - d0, 6);

    // random traffic: ready, bus latency and redirects
    rand_lat = 1'b1;
    d0 = n_deq;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        redirect_i = 1'b1; ready_i = 1'b0; redirect_pc_i = 16'($urandom);
        cyc();
        redirect_i = 1'b0; exp_pc = redirect_pc_i & 16'hFFFE;
        chk("rand_redir_valid", valid_o, 0);
      end else begin
        ready_i = ($urandom_range(0, 9) < 7);
        cyc();
      end
    end
    chk("rand_progress", (n_deq - d0) > 40, 1);

    // reset in the middle of a bus access with the queue non-empty
    rand_lat = 1'b0; lat = 6; ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 16'h001C; cyc();
    redirect_i = 1'b0; exp_pc = 16'h001C;
    for (int t = 0; t < 80 && !(wb_stb_o && valid_o); t++) cyc();
    chk("midbus_found", wb_stb_o && valid_o, 1);
    rst_n = 1'b0; cyc();
    chk("midrst_stb", wb_stb_o, 0);
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_instr", instr_o, 0);
    chk("midrst_pc", pc_o, 0);
    chk("midrst_npc", npc_o, 0);
    chk("midrst_adr", wb_adr_o, 0);
    cyc();
    n_ack = 0; lat = 0; exp_pc = 16'h0000;
    rst_n = 1'b1; ready_i = 1'b1;
    d0 = n_deq;
    for (int t = 0; t < 120 && n_deq < d0 + 8; t++) cyc();
    chk("restart_words", n_deq - d0, 8);
    chk("restart_acks", n_ack, REUSE ? 1 : 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the LC-3b pipeline; replaces the single-word, un-buffered fetch path that feeds the IF/ID register.
- Fetches whole cache lines over the wishbone ifetch port and holds the most recent line in a line buffer.
- Extracts sequential instruction words into a DEPTH-entry queue with valid/ready handoff to decode.
- Accepts a redirect (branch, JMP, TRAP target) from write-back that flushes all queued and in-flight work.

Parameters:
- WORD_W, 16, instruction/PC word width in bits.
- LINE_WORDS, 8, words per bus line (power of 2); line data width = WORD_W*LINE_WORDS.
- DEPTH, 4, instruction queue entries (power of 2, ≥2).
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- redirect_i  in  1  discard queue and in-flight fetch; restart at redirect_pc_i.
- redirect_pc_i  in  WORD_W  new fetch PC; bit 0 ignored (forced 0).
- wb_adr_o  out  WORD_W-log2(LINE_WORDS)-1  line address = fetch_pc[WORD_W-1:log2(LINE_WORDS)+1].
- wb_dat_i  in  WORD_W*LINE_WORDS  read line data.
- wb_ack_i  in  1  line data valid.
- wb_stb_o, wb_cyc_o  out  1  bus request (identical).
- wb_we_o  out  1  constant 0.
- instr_o  out  WORD_W  head-of-queue instruction.
- pc_o  out  WORD_W  address of instr_o.
- npc_o  out  WORD_W  pc_o+2 (mod 2^WORD_W), feeds IF/ID PC field.
- valid_o  out  1  queue non-empty.
- ready_i  in  1  decode accepts head this cycle.

Behaviour:
- Reset (rst_n low at posedge): fetch_pc=RESET_PC, line buffer invalid, count=0, rd/wr pointers 0, wb_stb_o=wb_cyc_o=0, valid_o=0, instr_o/pc_o/npc_o=0. Reset overrides redirect, ack, ready.
- Word select: word index = fetch_pc[log2(LINE_WORDS):1]; word k = wb_dat_i/buffer bits [WORD_W*k +: WORD_W].
- Per-cycle priority: reset > redirect > normal.
- Redirect: next cycle fetch_pc={redirect_pc_i[WORD_W-1:1],0}, count=0, valid_o=0; stb/cyc drop next cycle; ack in redirect cycle ignored (no enqueue, buffer not written); line buffer contents kept.
- Fetch FSM, 2 states:
  - HIT/IDLE: if count<DEPTH and buffer valid and tag==line(fetch_pc) → enqueue {fetch_pc, word}, fetch_pc+=2. If count<DEPTH and miss → go BUS, stb/cyc=1 registered. If full → hold.
  - BUS: stb/cyc=1, wb_adr_o=line(fetch_pc). On wb_ack_i: buffer←wb_dat_i, tag←line(fetch_pc), valid←1; enqueue the word same cycle (bypass, queue guaranteed not full since only dequeue occurs in BUS), fetch_pc+=2; return HIT/IDLE, stb/cyc=0 next cycle.
- fetch_pc wraps 0xFFFE→0x0000; crossing a line boundary causes a miss.
- Queue: enqueue only when count<DEPTH, evaluated on pre-dequeue count (full blocks enqueue even with simultaneous dequeue). Dequeue when valid_o&ready_i. Simultaneous enq+deq at 0<count<DEPTH: count unchanged. Enqueue→valid_o latency 1 cycle, no bypass from empty. Head outputs hold stable while valid_o&!ready_i. Pointers wrap mod DEPTH.
- Hit throughput: 1 word/cycle. Miss penalty: bus latency + 1.

Optional Feature:
- Macro IFETCH_LINE_REUSE_EN.
- Defined: line buffer hits as above.
- Undefined: buffer treated as always invalid; every word issues its own bus access (BUS each word); tag/valid storage not built. Queue and redirect behaviour unchanged.

Test Plan:
- Reset then ack line 0 with words 0x1000..0x1007, ready_i=1 → ONE bus access; instr_o 0x1000..0x1007 on consecutive cycles, pc_o 0x0000..0x000E, npc_o 0x0002..0x0010; second access at wb_adr_o=1.
- ready_i=0 with DEPTH=4 → exactly 4 enqueues, stb stays 0, instr_o held 0x1000; raise ready_i → resumes with no lost or duplicated words.
- Redirect to 0x0031 while queue holds 3 entries → valid_o=0 next cycle; next fetch pc_o=0x0030 (hit in buffered line 3 if present, else wb_adr_o=3).
- Redirect asserted in same cycle as wb_ack_i → acked word not enqueued, next instr_o comes from redirect PC.
- RESET_PC=16'hFFFC, LINE_WORDS=8 → pc_o 0xFFFC, 0xFFFE, 0x0000; npc_o of 0xFFFE is 0x0000; new bus access at line 0.
- rst_n low mid-BUS with queue non-empty → next cycle stb=0, valid_o=0, fetch restarts at RESET_PC; IFETCH_LINE_REUSE_EN undefined → 8 sequential words produce 8 bus accesses.
